// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : game_sequencer
// Brief    : Master game controller for the snake VGA design. Sequences
//            IDLE/PLAY/WIN/LOSE from a single start button and datapath
//            event pulses, generates the snake step tick with speed-up on
//            every target eaten, and tracks the score.
// Options  : define PAUSE_EN to let the start button pause/resume in PLAY.
// Revision : 1.0 - initial release
// ============================================================================
module game_sequencer #(
   parameter int TICK_DIV     = 10000000,
   parameter int TICK_STEP    = 500000,
   parameter int TICK_MIN     = 2000000,
   parameter int SCORE_TARGET = 10
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_btn_start,
   input  logic       i_target_eaten,
   input  logic       i_collision,
   output logic [1:0] o_play_state,
   output logic       o_move_tick,
   output logic       o_game_reset,
   output logic [7:0] o_score
);

   // Counter only needs to reach period-1; the period register must hold TICK_DIV itself.
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int PW = $clog2(TICK_DIV + 1);

   localparam logic [PW-1:0] c_period_init  = PW'(TICK_DIV);
   localparam logic [PW-1:0] c_period_min   = PW'(TICK_MIN);
   localparam logic [PW-1:0] c_period_step  = PW'(TICK_STEP);
   localparam logic [7:0]    c_score_target = 8'(SCORE_TARGET);
   localparam logic [7:0]    c_score_max    = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PLAY = 2'b01,
      ST_WIN  = 2'b10,
      ST_LOSE = 2'b11
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_count;
   logic [PW-1:0]   r_period;
   logic [7:0]      r_score;
   logic            r_move_tick;
   logic            r_game_reset;

   logic            r_btn_s1;
   logic            r_btn_s2;
   logic            r_btn_s2_d;

   logic            w_start;
   logic            w_wrap;
   logic [7:0]      w_score_inc;
   logic            w_win;
   logic [PW-1:0]   w_period_dec;

`ifdef PAUSE_EN
   logic            r_paused;
`endif

   // Two-flop synchroniser for the asynchronous button plus a delay flop for edge detection.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_btn_s1   <= 1'b0;
         r_btn_s2   <= 1'b0;
         r_btn_s2_d <= 1'b0;
      end else begin
         r_btn_s1   <= i_btn_start;
         r_btn_s2   <= r_btn_s1;
         r_btn_s2_d <= r_btn_s2;
      end
   end

   // Rising edge of the synchronised button: one start event per press, however long it is held.
   assign w_start = r_btn_s2 & ~r_btn_s2_d;

   // Wrap on >= so that a period shortened below the current count still wraps next cycle.
   assign w_wrap = ((32'(r_count) + 32'd1) >= 32'(r_period));

   // Score saturates rather than wrapping.
   assign w_score_inc = (r_score == c_score_max) ? r_score : (r_score + 8'd1);
   assign w_win       = (w_score_inc == c_score_target);

   // Compare before subtracting so the period never underflows below the floor.
   assign w_period_dec = (32'(r_period) >= (TICK_MIN + TICK_STEP)) ?
                         (r_period - c_period_step) : c_period_min;

   // Game state machine with registered play state, tick, reset pulse and score.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_count      <= '0;
         r_period     <= c_period_init;
         r_score      <= 8'd0;
         r_move_tick  <= 1'b0;
         r_game_reset <= 1'b0;
`ifdef PAUSE_EN
         r_paused     <= 1'b0;
`endif
      end else begin
         r_game_reset <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_count     <= '0;
               r_move_tick <= 1'b0;
`ifdef PAUSE_EN
               r_paused    <= 1'b0;
`endif
               if (w_start) begin
                  r_state      <= ST_PLAY;
                  r_game_reset <= 1'b1;
                  r_score      <= 8'd0;
                  r_period     <= c_period_init;
               end
            end

            ST_PLAY: begin
`ifdef PAUSE_EN
               // Start toggles pause; while paused the counter and events are frozen.
               if (w_start) begin
                  r_paused    <= ~r_paused;
                  r_move_tick <= 1'b0;
               end else if (r_paused) begin
                  r_move_tick <= 1'b0;
               end else
`endif
               if (i_collision) begin
                  // Collision wins over a simultaneous target: score is left untouched.
                  r_state     <= ST_LOSE;
                  r_count     <= '0;
                  r_move_tick <= 1'b0;
               end else if (i_target_eaten && w_win) begin
                  r_state     <= ST_WIN;
                  r_score     <= w_score_inc;
                  r_period    <= w_period_dec;
                  r_count     <= '0;
                  r_move_tick <= 1'b0;
               end else begin
                  if (i_target_eaten) begin
                     r_score  <= w_score_inc;
                     r_period <= w_period_dec;
                  end
                  if (w_wrap) begin
                     r_count     <= '0;
                     r_move_tick <= 1'b1;
                  end else begin
                     r_count     <= r_count + CW'(1);
                     r_move_tick <= 1'b0;
                  end
               end
            end

            default: begin
               // WIN and LOSE: hold the score, wait for start to return to IDLE.
               r_count     <= '0;
               r_move_tick <= 1'b0;
`ifdef PAUSE_EN
               r_paused    <= 1'b0;
`endif
               if (w_start) begin
                  r_state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign o_play_state = r_state;
   assign o_move_tick  = r_move_tick;
   assign o_game_reset = r_game_reset;
   assign o_score      = r_score;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_sequencer
// Brief    : Directed self-checking bench for game_sequencer. Two instances:
//            SCORE_TARGET=3 for the main game flow, SCORE_TARGET=10 for the
//            period floor. PAUSE_EN adds a pause/resume scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;

   logic       clk;
   logic       rst_n;
   logic       btn;
   logic       te;
   logic       col;
   logic [1:0] state1;
   logic       tick1;
   logic       grst1;
   logic [7:0] score1;

   logic       btn2;
   logic       te2;
   logic       col2;
   logic [1:0] state2;
   logic       tick2;
   logic       grst2;
   logic [7:0] score2;

   int n_checks = 0;
   int n_errors = 0;
   int n;

   game_sequencer #(
      .TICK_DIV(8), .TICK_STEP(2), .TICK_MIN(4), .SCORE_TARGET(3)
   ) u_dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_btn_start    (btn),
      .i_target_eaten (te),
      .i_collision    (col),
      .o_play_state   (state1),
      .o_move_tick    (tick1),
      .o_game_reset   (grst1),
      .o_score        (score1)
   );

   game_sequencer #(
      .TICK_DIV(8), .TICK_STEP(2), .TICK_MIN(4), .SCORE_TARGET(10)
   ) u_dut10 (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_btn_start    (btn2),
      .i_target_eaten (te2),
      .i_collision    (col2),
      .o_play_state   (state2),
      .o_move_tick    (tick2),
      .o_game_reset   (grst2),
      .o_score        (score2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Cycles until the next tick pulse of the chosen instance; limit+1 if none.
   task automatic wait_tick(input bit which, input int limit, output int cnt);
      bit seen;
      seen = 1'b0;
      cnt  = 0;
      while (!seen && cnt <= limit) begin
         step(1);
         cnt++;
         seen = which ? tick2 : tick1;
      end
      if (!seen) cnt = limit + 1;
   endtask

   task automatic count_ticks(input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         step(1);
         if (tick1) cnt++;
      end
   endtask

   initial begin
      rst_n = 1'b1;
      btn = 1'b0; te = 1'b0; col = 1'b0;
      btn2 = 1'b0; te2 = 1'b0; col2 = 1'b0;
      #2 rst_n = 1'b0;
      step(2);

      // Reset values
      chk("rst_state", 32'(state1), 0);
      chk("rst_tick",  32'(tick1),  0);
      chk("rst_grst",  32'(grst1),  0);
      chk("rst_score", 32'(score1), 0);
      rst_n = 1'b1;
      step(3);

      // Start: sampled at edge k, acts at edge k+2
      btn = 1'b1;
      step(2);
      chk("start_not_yet", 32'(state1), 0);
      step(1);
      chk("start_play",  32'(state1), 1);
      chk("start_grst",  32'(grst1),  1);
      chk("start_score", 32'(score1), 0);
      step(1);
      chk("grst_one_cycle", 32'(grst1), 0);
      step(19);
      chk("held_btn_play", 32'(state1), 1);
      btn = 1'b0;

      // Base period 8
      wait_tick(1'b0, 20, n);
      wait_tick(1'b0, 20, n);
      chk("period_8", 32'(n), 8);

      // First target right after a tick: period 6
      te = 1'b1; step(1); te = 1'b0;
      chk("score_1", 32'(score1), 1);
      wait_tick(1'b0, 20, n);
      chk("period_6_first", 32'(n), 5);
      wait_tick(1'b0, 20, n);
      chk("period_6", 32'(n), 6);

      // Second target: period 4
      te = 1'b1; step(1); te = 1'b0;
      chk("score_2", 32'(score1), 2);
      wait_tick(1'b0, 20, n);
      chk("period_4_first", 32'(n), 3);
      wait_tick(1'b0, 20, n);
      chk("period_4", 32'(n), 4);

      // Third target reaches SCORE_TARGET: WIN, tick stops
      te = 1'b1; step(1); te = 1'b0;
      chk("win_state", 32'(state1), 2);
      chk("win_score", 32'(score1), 3);
      chk("win_no_tick", 32'(tick1), 0);
      count_ticks(20, n);
      chk("win_ticks_stop", 32'(n), 0);
      chk("win_hold", 32'(state1), 2);

      // WIN -> IDLE keeps the score; events ignored in IDLE
      btn = 1'b1; step(3);
      chk("win_to_idle", 32'(state1), 0);
      chk("idle_score_held", 32'(score1), 3);
      btn = 1'b0; step(3);
      te = 1'b1; step(1); te = 1'b0;
      chk("idle_te_ignored", 32'(score1), 3);
      chk("idle_stays", 32'(state1), 0);

      // New game, then collision and target in the same cycle
      btn = 1'b1; step(3);
      chk("restart_play",  32'(state1), 1);
      chk("restart_score", 32'(score1), 0);
      chk("restart_grst",  32'(grst1),  1);
      btn = 1'b0; step(3);
      te = 1'b1; step(1); te = 1'b0;
      chk("score_1_again", 32'(score1), 1);
      te = 1'b1; col = 1'b1; step(1); te = 1'b0; col = 1'b0;
      chk("collide_lose",  32'(state1), 3);
      chk("collide_score", 32'(score1), 1);
      chk("collide_tick",  32'(tick1),  0);
      btn = 1'b1; step(3);
      chk("lose_to_idle", 32'(state1), 0);
      chk("lose_idle_score", 32'(score1), 1);
      btn = 1'b0; step(3);
      btn = 1'b1; step(3);
      chk("replay", 32'(state1), 1);
      chk("replay_score", 32'(score1), 0);
      btn = 1'b0; step(3);

      // Period floor with SCORE_TARGET=10: 8->6->4->4->4
      btn2 = 1'b1; step(3);
      chk("d10_play", 32'(state2), 1);
      btn2 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         te2 = 1'b1; step(1); te2 = 1'b0; step(1);
      end
      chk("d10_score_5", 32'(score2), 5);
      chk("d10_still_play", 32'(state2), 1);
      wait_tick(1'b1, 20, n);
      wait_tick(1'b1, 20, n);
      chk("d10_floor_a", 32'(n), 4);
      wait_tick(1'b1, 20, n);
      chk("d10_floor_b", 32'(n), 4);

      // Asynchronous reset mid-game, between clock edges
      te = 1'b1; step(1); te = 1'b0;
      chk("pre_rst_score", 32'(score1), 1);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_state",  32'(state1), 0);
      chk("arst_score",  32'(score1), 0);
      chk("arst_tick",   32'(tick1),  0);
      chk("arst_grst",   32'(grst1),  0);
      chk("arst_state2", 32'(state2), 0);
      chk("arst_score2", 32'(score2), 0);
      step(1);
      rst_n = 1'b1;
      step(2);

`ifdef PAUSE_EN
      // Pause freezes the count and ignores events; resume continues the count
      btn = 1'b1; step(3);
      chk("p_play", 32'(state1), 1);
      btn = 1'b0; step(3);
      wait_tick(1'b0, 20, n);
      btn = 1'b1; step(3); btn = 1'b0;
      count_ticks(30, n);
      chk("p_no_ticks", 32'(n), 0);
      col = 1'b1; step(1); col = 1'b0;
      chk("p_col_ignored", 32'(state1), 1);
      btn = 1'b1; step(3); btn = 1'b0;
      wait_tick(1'b0, 20, n);
      chk("p_resume_count", 32'(n), 6);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
